// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared state encoding, funct codes and defaults for alu_op_sequencer
package alu_seq_pkg;

   localparam logic [1:0] ALUOP_RTYPE_DEFAULT = 2'b11;
   localparam int         DATA_W_DEFAULT      = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      EXEC  = 2'd2,
      WRITE = 2'd3
   } seq_state_t;

   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_SLT = 6'b101010;

   function automatic logic funct_supported(input logic [5:0] f);
      return f inside {FUNCT_ADD, FUNCT_SUB, FUNCT_AND, FUNCT_OR, FUNCT_SLT};
   endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// rtl/alu_op_sequencer_if.sv - request/completion handshake bundle for alu_op_sequencer
interface alu_op_sequencer_if #(
   parameter int DATA_W = 8
);
   logic              req_valid;
   logic              req_ready;
   logic [5:0]        req_funct;
   logic [2:0]        req_rs;
   logic [2:0]        req_rt;
   logic [2:0]        req_rd;
   logic              done;
   logic              done_err;
   logic [DATA_W-1:0] done_result;

   modport master (
      output req_valid, req_funct, req_rs, req_rt, req_rd,
      input  req_ready, done, done_err, done_result
   );

   modport slave (
      input  req_valid, req_funct, req_rs, req_rt, req_rd,
      output req_ready, done, done_err, done_result
   );
endinterface

// File: rtl/alu_seq_wrmux.sv
// rtl/alu_seq_wrmux.sv - regfile write-port arbiter: external writer vs sequencer write-back
module alu_seq_wrmux #(
   parameter int DATA_W = 8
) (
   input  logic              ext_sel,
   input  logic [2:0]        ext_wa,
   input  logic [DATA_W-1:0] ext_wd,
   input  logic              seq_sel,
   input  logic              seq_ok,
   input  logic [2:0]        seq_wa,
   input  logic [DATA_W-1:0] seq_wd,
   output logic [2:0]        wa,
   output logic [DATA_W-1:0] wd,
   output logic              regwrite
);
   always_comb begin
      wa       = '0;
      wd       = seq_wd;
      regwrite = 1'b0;
      if (ext_sel) begin
         wa       = ext_wa;
         wd       = ext_wd;
         regwrite = 1'b1;
      end else if (seq_sel) begin
         wa       = seq_wa;
         // r0 is the hardwired zero register, so write-back there is dropped.
         regwrite = seq_ok && (seq_wa != 3'd0);
      end
   end
endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - multi-cycle R-type read/exec/write sequencer (optional ALU_SEQ_OPCOUNT_EN counters)
module alu_op_sequencer
   import alu_seq_pkg::*;
#(
   parameter logic [1:0] ALUOP_RTYPE = ALUOP_RTYPE_DEFAULT,
   parameter int         DATA_W      = DATA_W_DEFAULT
) (
   input  logic              clk,
   input  logic              reset_n,
   alu_op_sequencer_if.slave req_if,
   input  logic              ext_we,
   input  logic [2:0]        ext_wa,
   input  logic [DATA_W-1:0] ext_wd,
   output logic              ext_ready,
`ifdef ALU_SEQ_OPCOUNT_EN
   output logic [15:0]       op_count,
   output logic [7:0]        err_count,
`endif
   output logic [2:0]        ra1,
   output logic [2:0]        ra2,
   input  logic [DATA_W-1:0] rd1,
   input  logic [DATA_W-1:0] rd2,
   output logic [DATA_W-1:0] a,
   output logic [DATA_W-1:0] b,
   output logic [1:0]        aluop,
   output logic [5:0]        funct,
   input  logic [DATA_W-1:0] result,
   output logic [2:0]        wa,
   output logic [DATA_W-1:0] wd,
   output logic              regwrite
);
   seq_state_t        state;
   logic [5:0]        funct_q;
   logic [2:0]        rd_q;
   logic [DATA_W-1:0] res_q;
   logic              accept;
   logic              ext_sel;

   // The external writer has priority in IDLE; a pending request simply waits.
   assign ext_sel          = (state == IDLE) && ext_we;
   assign accept           = (state == IDLE) && !ext_we && req_if.req_valid;
   assign req_if.req_ready = (state == IDLE) && !ext_we;
   assign ext_ready        = (state == IDLE);
   assign req_if.done_result = res_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state           <= IDLE;
         funct_q         <= '0;
         rd_q            <= '0;
         res_q           <= '0;
         ra1             <= '0;
         ra2             <= '0;
         a               <= '0;
         b               <= '0;
         aluop           <= '0;
         funct           <= '0;
         req_if.done     <= 1'b0;
         req_if.done_err <= 1'b0;
      end else begin
         req_if.done     <= 1'b0;
         req_if.done_err <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  funct_q <= req_if.req_funct;
                  rd_q    <= req_if.req_rd;
                  ra1     <= req_if.req_rs;
                  ra2     <= req_if.req_rt;
                  state   <= READ;
               end
            end
            READ: begin
               a     <= rd1;
               b     <= rd2;
               ra1   <= '0;
               ra2   <= '0;
               aluop <= ALUOP_RTYPE;
               funct <= funct_q;
               state <= EXEC;
            end
            EXEC: begin
               // res_q doubles as write data and the held done_result.
               res_q           <= result;
               aluop           <= '0;
               funct           <= '0;
               req_if.done     <= 1'b1;
               req_if.done_err <= !funct_supported(funct_q);
               state           <= WRITE;
            end
            WRITE:   state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   alu_seq_wrmux #(.DATA_W(DATA_W)) u_wrmux (
      .ext_sel  (ext_sel),
      .ext_wa   (ext_wa),
      .ext_wd   (ext_wd),
      .seq_sel  (state == WRITE),
      .seq_ok   (funct_supported(funct_q)),
      .seq_wa   (rd_q),
      .seq_wd   (res_q),
      .wa       (wa),
      .wd       (wd),
      .regwrite (regwrite)
   );

`ifdef ALU_SEQ_OPCOUNT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         op_count  <= '0;
         err_count <= '0;
      end else if (req_if.done) begin
         if (!req_if.done_err)
            op_count <= op_count + 16'd1;
         else if (err_count != 8'hff)
            err_count <= err_count + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - randomized self-checking bench for alu_op_sequencer
module tb_alu_op_sequencer;
   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       ext_we = 1'b0;
   logic [2:0] ext_wa = '0;
   logic [7:0] ext_wd = '0;
   logic       ext_ready;
   logic [2:0] ra1, ra2, wa;
   logic [7:0] rd1, rd2, a, b, alu_res, wd;
   logic [1:0] aluop;
   logic [5:0] funct;
   logic       regwrite;
`ifdef ALU_SEQ_OPCOUNT_EN
   logic [15:0] op_count;
   logic [7:0]  err_count;
`endif

   always #5 clk = ~clk;

   alu_op_sequencer_if rif ();

   alu_op_sequencer dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req_if    (rif.slave),
      .ext_we    (ext_we),
      .ext_wa    (ext_wa),
      .ext_wd    (ext_wd),
      .ext_ready (ext_ready),
`ifdef ALU_SEQ_OPCOUNT_EN
      .op_count  (op_count),
      .err_count (err_count),
`endif
      .ra1       (ra1),
      .ra2       (ra2),
      .rd1       (rd1),
      .rd2       (rd2),
      .a         (a),
      .b         (b),
      .aluop     (aluop),
      .funct     (funct),
      .result    (alu_res),
      .wa        (wa),
      .wd        (wd),
      .regwrite  (regwrite)
   );

   // Environment: the regfile and the ALU/alucontrol pair the sequencer drives.
   logic [7:0] rf [8] = '{default: 8'h00};
   always @(posedge clk) if (regwrite) rf[wa] <= wd;
   assign rd1 = rf[ra1];
   assign rd2 = rf[ra2];

   always_comb begin
      alu_res = 8'h00;
      if (aluop == 2'b11) begin
         case (funct)
            6'b100000: alu_res = a + b;
            6'b100010: alu_res = a - b;
            6'b100100: alu_res = a & b;
            6'b100101: alu_res = a | b;
            6'b101010: alu_res = {7'd0, $signed(a) < $signed(b)};
            default:   alu_res = 8'h00;
         endcase
      end
   end

   int checks = 0;
   int failures = 0;
   int mrf [8];
   int exp_ops = 0;
   int exp_errs = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic bit is_supported(input int f);
      return f == 32 || f == 34 || f == 36 || f == 37 || f == 42;
   endfunction

   function automatic int to_signed8(input int x);
      return (x > 127) ? x - 256 : x;
   endfunction

   function automatic int ref_alu(input int f, input int x, input int y);
      case (f)
         32:      return (x + y) % 256;
         34:      return (x - y + 256) % 256;
         36:      return x & y;
         37:      return x | y;
         42:      return (to_signed8(x) < to_signed8(y)) ? 1 : 0;
         default: return 0;
      endcase
   endfunction

   task automatic ext_write(input int wa_v, input int wd_v);
      @(negedge clk);
      ext_we = 1'b1;
      ext_wa = 3'(wa_v);
      ext_wd = 8'(wd_v);
      #1;
      check("ext_ready", ext_ready, 1);
      check("ext_regwrite", regwrite, 1);
      check("ext_req_ready", rif.req_ready, 0);
      @(posedge clk);
      #1;
      ext_we = 1'b0;
      mrf[wa_v] = wd_v;
   endtask

   task automatic run_op(input int f, input int rs_v, input int rt_v, input int rd_v,
                         input bit with_ext, input int ewa, input int ewd);
      int  acc;
      int  done_at;
      int  exp_res;
      bit  ok;
      bit  got_done;
      ok = is_supported(f);
      if (with_ext) mrf[ewa] = ewd;
      exp_res = ref_alu(f, mrf[rs_v], mrf[rt_v]);
      acc = with_ext ? 1 : 0;
      got_done = 1'b0;
      done_at = 99;
      @(negedge clk);
      rif.req_valid = 1'b1;
      rif.req_funct = 6'(f);
      rif.req_rs = 3'(rs_v);
      rif.req_rt = 3'(rt_v);
      rif.req_rd = 3'(rd_v);
      if (with_ext) begin
         ext_we = 1'b1;
         ext_wa = 3'(ewa);
         ext_wd = 8'(ewd);
      end
      #1;
      if (with_ext) begin
         check("collide_req_ready", rif.req_ready, 0);
         check("collide_regwrite", regwrite, 1);
      end else begin
         check("accept_ready", rif.req_ready, 1);
      end
      for (int c = 1; c <= 8 && !got_done; c++) begin
         @(negedge clk);
         if (c == 1 && with_ext) ext_we = 1'b0;
         if (c == acc + 1) begin
            rif.req_valid = 1'b0;
            ext_we = 1'b1;
            ext_wa = 3'((rd_v == 0) ? 1 : rd_v);
            ext_wd = 8'($urandom);
         end
         if (c == acc + 2) ext_we = 1'b0;
         #1;
         if (rif.done) begin
            got_done = 1'b1;
            done_at = c;
         end else begin
            check("busy_regwrite", regwrite, 0);
            if (c > acc) begin
               check("busy_req_ready", rif.req_ready, 0);
               check("busy_ext_ready", ext_ready, 0);
            end
            if (c == acc + 2) begin
               check("operand_a", a, mrf[rs_v]);
               check("operand_b", b, mrf[rt_v]);
               check("exec_aluop", aluop, 3);
               check("exec_funct", funct, f);
            end
         end
      end
      check("done_cycle", done_at, acc + 3);
      if (got_done) begin
         check("done_err", rif.done_err, !ok);
         if (ok) check("done_result", rif.done_result, exp_res);
         check("write_strobe", regwrite, ok && rd_v != 0);
         if (ok && rd_v != 0) check("write_addr", wa, rd_v);
         if (ok && rd_v != 0) mrf[rd_v] = exp_res;
         if (ok) exp_ops = (exp_ops + 1) % 65536;
         else if (exp_errs < 255) exp_errs++;
      end
      @(negedge clk);
      #1;
      check("done_pulse_end", rif.done, 0);
      check("dest_reg", rf[rd_v], mrf[rd_v]);
      if (ok) check("result_held", rif.done_result, exp_res);
   endtask

   task automatic reset_mid(input int f, input int rs_v, input int rt_v, input int rd_v, input int at);
      @(negedge clk);
      rif.req_valid = 1'b1;
      rif.req_funct = 6'(f);
      rif.req_rs = 3'(rs_v);
      rif.req_rt = 3'(rt_v);
      rif.req_rd = 3'(rd_v);
      for (int c = 1; c <= at; c++) begin
         @(negedge clk);
         if (c == 1) rif.req_valid = 1'b0;
      end
      #1;
      if (at == 3) check("pre_reset_regwrite", regwrite, 1);
      if (at == 2) check("exec_no_done", rif.done, 0);
      reset_n = 1'b0;
      #1;
      check("rst_regwrite", regwrite, 0);
      check("rst_done", rif.done, 0);
      check("rst_req_ready", rif.req_ready, 1);
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      exp_ops = 0;
      exp_errs = 0;
      #1;
      check("rst_dest_unchanged", rf[rd_v], mrf[rd_v]);
      check("rst_release_ready", rif.req_ready, 1);
      check("rst_done_result", rif.done_result, 0);
      check("rst_no_done", rif.done, 0);
   endtask

   initial begin
      int f;
      for (int i = 0; i < 8; i++) mrf[i] = 0;
      rif.req_valid = 1'b0;
      rif.req_funct = '0;
      rif.req_rs = '0;
      rif.req_rt = '0;
      rif.req_rd = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_req_ready", rif.req_ready, 1);
      check("reset_ext_ready", ext_ready, 1);
      check("reset_done", rif.done, 0);
      check("reset_done_err", rif.done_err, 0);
      check("reset_done_result", rif.done_result, 0);
      check("reset_regwrite", regwrite, 0);
      check("reset_ab", {a, b}, 0);
      check("reset_aluop_funct", {aluop, funct}, 0);
      check("reset_ra_wa_wd", {ra1, ra2, wa, wd}, 0);
      @(negedge clk);
      reset_n = 1'b1;

      ext_write(1, 1);
      ext_write(2, 2);
      #1;
      check("preload_r1", rf[1], 1);
      check("preload_r2", rf[2], 2);

      run_op(32, 1, 2, 3, 1'b0, 0, 0);
      run_op(34, 1, 2, 4, 1'b0, 0, 0);
      run_op(42, 1, 2, 7, 1'b0, 0, 0);
      run_op(42, 4, 1, 5, 1'b0, 0, 0);
      run_op(37, 1, 2, 0, 1'b0, 0, 0);
      check("r0_zero", rf[0], 0);
      run_op(0, 1, 2, 6, 1'b0, 0, 0);
      run_op(32, 5, 1, 6, 1'b1, 5, 9);
      reset_mid(34, 1, 2, 3, 2);
      reset_mid(32, 4, 1, 3, 3);

      repeat (40) begin
         if ($urandom_range(0, 3) == 0)
            ext_write($urandom_range(1, 7), $urandom_range(0, 255));
         case ($urandom_range(0, 5))
            0: f = 32;
            1: f = 34;
            2: f = 36;
            3: f = 37;
            4: f = 42;
            default: f = $urandom_range(0, 63);
         endcase
         run_op(f, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                ($urandom_range(0, 7) == 0), $urandom_range(1, 7), $urandom_range(0, 255));
      end

      for (int i = 0; i < 8; i++) check("final_reg", rf[i], mrf[i]);
`ifdef ALU_SEQ_OPCOUNT_EN
      check("op_count", op_count, exp_ops);
      check("err_count", err_count, exp_errs);
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end
endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Multi-cycle controller that owns the 8-bit ALU, the alucontrol block and the 8x8 regfile ports.
- Accepts one R-type request (funct, rs, rt, rd) by valid/ready handshake.
- Sequences regfile read, ALU execute and regfile write-back, then pulses done.
- Also arbitrates the regfile write port between the sequencer and an external preload/debug writer.

Parameters:
- ALUOP_RTYPE, 2'b11, aluop value driven to alucontrol during EXEC (selects funct decode).
- DATA_W, 8, datapath width; fixed 8 for this core, used for port sizing only.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept request
- req_funct  in  6  R-type funct field
- req_rs  in  3  source register A
- req_rt  in  3  source register B
- req_rd  in  3  destination register
- done  out  1  one-cycle completion pulse
- done_err  out  1  qualifies done: funct unsupported, no write performed
- done_result  out  8  ALU result of completed op, held until next done
- ext_we  in  1  external regfile write request
- ext_wa  in  3  external write address
- ext_wd  in  8  external write data
- ext_ready  out  1  external write accepted this cycle
- ra1, ra2  out  3  regfile read addresses
- rd1, rd2  in  8  regfile read data (combinational)
- a, b  out  8  ALU operands, registered
- aluop  out  2  to alucontrol
- funct  out  6  to alucontrol
- result  in  8  ALU result
- wa  out  3  regfile write address
- wd  out  8  regfile write data
- regwrite  out  1  regfile write strobe

Behaviour:
- Reset values (async, immediate):
  - state=IDLE; req_ready=1; ext_ready=1.
  - done=0, done_err=0, done_result=0.
  - regwrite=0; a=b=wa=wd=ra1=ra2=0; aluop=0; funct=0.
- FSM IDLE -> READ -> EXEC -> WRITE -> IDLE.
- IDLE:
  - req_ready=ext_ready=1.
  - If ext_we=1: combinationally wa=ext_wa, wd=ext_wd, regwrite=1; req_ready forced 0 this cycle. External write wins; request stays pending.
  - Else if req_valid=1: latch funct/rs/rt/rd, go to READ.
- READ: ra1=rs, ra2=rt; at clock edge capture a<=rd1, b<=rd2.
- EXEC: aluop=ALUOP_RTYPE, funct=latched funct; at edge capture result into wd register.
- WRITE:
  - wa=rd; regwrite=1 only if funct is supported AND rd!=0.
  - done=1 for exactly this cycle; done_result=captured result; done_err=1 if funct unsupported.
  - Next state IDLE.
- Supported funct values: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt. Any other value is treated as an error.
- Latency: handshake at cycle 0 -> done at cycle 3. Next acceptance no earlier than cycle 4; maximum throughput 1 op per 4 cycles.
- req_ready=0 and ext_ready=0 in READ/EXEC/WRITE; ext_we is ignored (dropped) there.
- Arithmetic:
  - 8-bit modulo wrap (1-2=255).
  - slt is signed 8-bit compare, result 0 or 1.
- rd=0: write suppressed; done and done_result still produced.
- rs/rt equal to the previous rd: correct, because write-back completes before the next READ.
- reset_n low mid-operation: op is abandoned, no write, no done; regwrite drops immediately.

Optional Feature:
- Macro: ALU_SEQ_OPCOUNT_EN.
- Defined:
  - Adds output op_count [15:0], reset to 0.
  - Increments on each done with done_err=0; wraps 65535->0.
  - Adds output err_count [7:0], incrementing on done with done_err=1 and saturating at 255.
- Undefined: neither port exists; no counters are synthesised.

Decomposition:
- Shared package alu_seq_pkg holds:
  - state encoding enum (IDLE, READ, EXEC, WRITE);
  - funct constants FUNCT_ADD/SUB/AND/OR/SLT;
  - ALUOP_RTYPE default.
- One natural sub-module: alu_seq_wrmux, the combinational regfile write-port arbiter (ext vs sequencer, rd==0 suppression).
- FSM and operand registers stay in the top.

Test Plan:
- ext_we preload r1=1, r2=2 in IDLE -> ext_ready=1, regwrite=1 each cycle; rd1=1, rd2=2 on read-back.
- add rs=1 rt=2 rd=3 -> done at cycle 3, done_result=3, done_err=0, r3=3.
- sub rs=1 rt=2 rd=4 -> done_result=255, r4=255. slt rs=1 rt=2 rd=7 -> r7=1. slt rs=4 rt=1 -> 1 (signed: -1<1).
- or rd=0 -> done=1, done_result=3, regwrite never asserted, r0 stays 0. funct=000000 -> done_err=1, no write.
- ext_we and req_valid together in IDLE -> external write first, req_ready=0; request accepted next cycle; done 4 cycles after the original assertion.
- reset_n pulsed low during EXEC -> regwrite=0 immediately, no done, destination register unchanged, req_ready=1 after release.
